placar_jogo: RTL and testbench

Round and match controller for the light-cycle game, downstream of the two player blocks. It consumes each player's end-of-game level, resolves round winners (including near-simultaneous crashes), keeps scores, and drives the 7-segment displays. It also generates the `reiniciar` pulse that clears player state and the trail framebuffer between rounds.

---
 rtl/placar_jogo_if.sv | 24 ++
 rtl/placar_jogo.sv | 190 +++++++++++++++++++
 tb/tb_placar_jogo.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/placar_jogo_if.sv
// Player crash levels and restart request in; round control, scores and 7-segment digits out.
interface placar_jogo_if;
    logic       fim_jog1;
    logic       fim_jog2;
    logic       iniciar;
    logic       reiniciar;
    logic       jogo_ativo;
    logic [3:0] pontos_jog1;
    logic [3:0] pontos_jog2;
    logic [1:0] vencedor;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;

    modport master (
        output fim_jog1, fim_jog2, iniciar,
        input  reiniciar, jogo_ativo, pontos_jog1, pontos_jog2, vencedor, HEX0, HEX1, HEX2
    );

    modport slave (
        input  fim_jog1, fim_jog2, iniciar,
        output reiniciar, jogo_ativo, pontos_jog1, pontos_jog2, vencedor, HEX0, HEX1, HEX2
    );
endinterface

// File: rtl/placar_jogo.sv
// Light-cycle round/match controller: crash pin to state in 2 cycles, HEX one cycle after its source.
// No backpressure; crash/start inputs are levels sampled every cycle, outputs are registered.
module placar_jogo #(
    parameter int PONTOS_VITORIA = 5,
    parameter int JANELA_CICLOS  = 420000,
    parameter int ESPERA_CICLOS  = 25000000,
    parameter int LIMPEZA_CICLOS = 307200
) (
    input logic          VGA_CLK,
    input logic          reset,
    placar_jogo_if.slave bus
);
    typedef enum logic [2:0] {LIMPA, JOGANDO, DECIDE, PAUSA, FIM_PARTIDA} estado_t;

    localparam logic [24:0] LIMPA_FIM  = 25'(LIMPEZA_CICLOS - 1);
    localparam logic [24:0] JANELA_FIM = 25'(JANELA_CICLOS - 1);
    localparam logic [24:0] ESPERA_FIM = 25'(ESPERA_CICLOS - 1);
    localparam logic [3:0]  META       = 4'(PONTOS_VITORIA);

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic fim1_r, fim1_p, fim2_r, fim2_p, ini_r, ini_p;
    logic sobe1, sobe2, sobe_ini;

    // Previous-value registers always follow the sampled level, so a crash level
    // still high when LIMPA ends has no edge and must fall and rise again.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            fim1_r <= 1'b0;
            fim1_p <= 1'b0;
            fim2_r <= 1'b0;
            fim2_p <= 1'b0;
            ini_r  <= 1'b0;
            ini_p  <= 1'b0;
        end else begin
            fim1_r <= bus.fim_jog1;
            fim2_r <= bus.fim_jog2;
            ini_r  <= bus.iniciar;
            fim1_p <= fim1_r;
            fim2_p <= fim2_r;
            ini_p  <= ini_r;
        end
    end

    assign sobe1    = fim1_r & ~fim1_p;
    assign sobe2    = fim2_r & ~fim2_p;
    assign sobe_ini = ini_r & ~ini_p;

    estado_t     estado, estado_nx;
    logic [24:0] cnt, cnt_nx;
    logic [3:0]  pts1, pts1_nx, pts2, pts2_nx;
    logic [1:0]  venc, venc_nx;
    logic        primeiro, primeiro_nx;   // 0: player 1 crashed first, 1: player 2

    always_comb begin
        estado_nx   = estado;
        cnt_nx      = cnt + 25'd1;
        pts1_nx     = pts1;
        pts2_nx     = pts2;
        venc_nx     = venc;
        primeiro_nx = primeiro;
        case (estado)
            LIMPA: begin
                if (cnt == LIMPA_FIM) begin
                    estado_nx = JOGANDO;
                    cnt_nx    = '0;
                end
            end
            JOGANDO: begin
                cnt_nx = '0;
                if (sobe1 && sobe2) begin
                    venc_nx   = 2'd3;
                    estado_nx = PAUSA;
                end else if (sobe1) begin
                    primeiro_nx = 1'b0;
                    estado_nx   = DECIDE;
                end else if (sobe2) begin
                    primeiro_nx = 1'b1;
                    estado_nx   = DECIDE;
                end
            end
            DECIDE: begin
                if (primeiro ? sobe1 : sobe2) begin
                    venc_nx   = 2'd3;
                    estado_nx = PAUSA;
                    cnt_nx    = '0;
                end else if (cnt == JANELA_FIM) begin
                    estado_nx = PAUSA;
                    cnt_nx    = '0;
                    if (primeiro) begin
                        venc_nx = 2'd1;
                        if (pts1 < META) pts1_nx = pts1 + 4'd1;
                    end else begin
                        venc_nx = 2'd2;
                        if (pts2 < META) pts2_nx = pts2 + 4'd1;
                    end
                end
            end
            PAUSA: begin
                if (cnt == ESPERA_FIM) begin
                    cnt_nx    = '0;
                    estado_nx = (pts1 == META || pts2 == META) ? FIM_PARTIDA : LIMPA;
                end
            end
            FIM_PARTIDA: begin
                cnt_nx = '0;
                if (sobe_ini) begin
                    pts1_nx   = '0;
                    pts2_nx   = '0;
                    venc_nx   = 2'd0;
                    estado_nx = LIMPA;
                end
            end
            default: begin
                estado_nx = LIMPA;
                cnt_nx    = '0;
            end
        endcase
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            estado   <= LIMPA;
            cnt      <= '0;
            pts1     <= '0;
            pts2     <= '0;
            venc     <= 2'd0;
            primeiro <= 1'b0;
        end else begin
            estado   <= estado_nx;
            cnt      <= cnt_nx;
            pts1     <= pts1_nx;
            pts2     <= pts2_nx;
            venc     <= venc_nx;
            primeiro <= primeiro_nx;
        end
    end

    logic [6:0] status;
    logic [6:0] hex0, hex1, hex2;

    always_comb begin
        status = 7'h7F;
        if (estado == PAUSA) begin
            case (venc)
                2'd1:    status = seg7(4'd1);
                2'd2:    status = seg7(4'd2);
                2'd3:    status = 7'h3F;
                default: status = 7'h7F;
            endcase
        end else if (estado == FIM_PARTIDA) begin
            status = (pts1 > pts2) ? seg7(4'd1) : seg7(4'd2);
        end
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            hex0 <= 7'h40;
            hex1 <= 7'h40;
            hex2 <= 7'h7F;
        end else begin
            hex0 <= seg7(pts1);
            hex1 <= seg7(pts2);
            hex2 <= status;
        end
    end

    assign bus.reiniciar   = (estado == LIMPA);
    assign bus.jogo_ativo  = (estado == JOGANDO) || (estado == DECIDE);
    assign bus.pontos_jog1 = pts1;
    assign bus.pontos_jog2 = pts2;
    assign bus.vencedor    = venc;
    assign bus.HEX0        = hex0;
    assign bus.HEX1        = hex1;
    assign bus.HEX2        = hex2;
endmodule

// File: tb/tb_placar_jogo.sv
// Bench for placar_jogo: directed rounds then random crash/start activity against a countdown model.
module tb_placar_jogo;
    localparam int W = 2;
    localparam int J = 4;
    localparam int E = 3;
    localparam int L = 5;

    localparam int M_LIMPA  = 0;
    localparam int M_JOGO   = 1;
    localparam int M_DECIDE = 2;
    localparam int M_PAUSA  = 3;
    localparam int M_FIM    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    placar_jogo_if bus ();

    placar_jogo #(
        .PONTOS_VITORIA(W),
        .JANELA_CICLOS (J),
        .ESPERA_CICLOS (E),
        .LIMPEZA_CICLOS(L)
    ) dut (
        .VGA_CLK(clk),
        .reset  (reset),
        .bus    (bus)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase plus cycles-left countdown, pin history for edges
    int   m_fase, m_left, m_p1, m_p2, m_venc, m_first;
    logic [6:0] m_h0, m_h1, m_h2;
    logic a1, b1, a2, b2, ai, bi;   // pin values one and two edges back

    function automatic logic [6:0] seg(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] m_status();
        if (m_fase == M_PAUSA) return (m_venc == 3) ? 7'h3F : seg(m_venc == 0 ? 15 : m_venc);
        if (m_fase == M_FIM) return seg(m_p1 > m_p2 ? 1 : 2);
        return 7'h7F;
    endfunction

    task automatic model_reset();
        m_fase = M_LIMPA; m_left = L; m_p1 = 0; m_p2 = 0; m_venc = 0; m_first = 0;
        m_h0 = 7'h40; m_h1 = 7'h40; m_h2 = 7'h7F;
        a1 = 0; b1 = 0; a2 = 0; b2 = 0; ai = 0; bi = 0;
    endtask

    task automatic model_step(input logic f1, input logic f2, input logic ini);
        logic s1, s2, si;
        logic [6:0] n0, n1, n2;
        s1 = a1 && !b1;
        s2 = a2 && !b2;
        si = ai && !bi;
        n0 = seg(m_p1); n1 = seg(m_p2); n2 = m_status();
        case (m_fase)
            M_LIMPA: begin
                m_left--;
                if (m_left == 0) m_fase = M_JOGO;
            end
            M_JOGO: begin
                if (s1 && s2) begin
                    m_venc = 3; m_fase = M_PAUSA; m_left = E;
                end else if (s1 || s2) begin
                    m_first = s1 ? 1 : 2; m_fase = M_DECIDE; m_left = J;
                end
            end
            M_DECIDE: begin
                if ((m_first == 1) ? s2 : s1) begin
                    m_venc = 3; m_fase = M_PAUSA; m_left = E;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_venc = 3 - m_first;
                        if (m_venc == 1) m_p1 = (m_p1 + 1 > W) ? W : m_p1 + 1;
                        else m_p2 = (m_p2 + 1 > W) ? W : m_p2 + 1;
                        m_fase = M_PAUSA; m_left = E;
                    end
                end
            end
            M_PAUSA: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_p1 == W || m_p2 == W) m_fase = M_FIM;
                    else begin m_fase = M_LIMPA; m_left = L; end
                end
            end
            default: begin
                if (si) begin
                    m_p1 = 0; m_p2 = 0; m_venc = 0; m_fase = M_LIMPA; m_left = L;
                end
            end
        endcase
        m_h0 = n0; m_h1 = n1; m_h2 = n2;
        b1 = a1; a1 = f1; b2 = a2; a2 = f2; bi = ai; ai = ini;
    endtask

    task automatic compare_all();
        chk("reiniciar",   32'(bus.reiniciar),   32'(m_fase == M_LIMPA));
        chk("jogo_ativo",  32'(bus.jogo_ativo),  32'(m_fase == M_JOGO || m_fase == M_DECIDE));
        chk("pontos_jog1", 32'(bus.pontos_jog1), 32'(m_p1));
        chk("pontos_jog2", 32'(bus.pontos_jog2), 32'(m_p2));
        chk("vencedor",    32'(bus.vencedor),    32'(m_venc));
        chk("HEX0",        32'(bus.HEX0),        32'(m_h0));
        chk("HEX1",        32'(bus.HEX1),        32'(m_h1));
        chk("HEX2",        32'(bus.HEX2),        32'(m_h2));
    endtask

    // Called at a falling edge: check, drive pins for the next rising edge, advance model.
    task automatic tick(input logic f1, input logic f2, input logic ini);
        compare_all();
        bus.fim_jog1 = f1;
        bus.fim_jog2 = f2;
        bus.iniciar  = ini;
        model_step(f1, f2, ini);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic espera(input int fase, input logic f1, input logic f2);
        for (int i = 0; i < 200; i++) begin
            if (m_fase == fase) return;
            tick(f1, f2, 1'b0);
        end
        chk("espera_timeout", 32'(m_fase), 32'(fase));
    endtask

    // One round: player n raises its crash level at cycle a/b after play starts (-1 = never).
    task automatic ronda(input int a, input int b);
        espera(M_JOGO, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            tick(a >= 0 && i >= a, b >= 0 && i >= b, 1'b0);
            if (m_fase == M_LIMPA || m_fase == M_FIM) return;
        end
        chk("ronda_timeout", 32'(m_fase), 32'(M_LIMPA));
    endtask

    logic r1, r2, ri;

    initial begin
        bus.fim_jog1 = 1'b0;
        bus.fim_jog2 = 1'b0;
        bus.iniciar  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        espera(M_JOGO, 1'b0, 1'b0);
        ronda(0, -1);      // player 1 crashes alone
        ronda(4, 0);       // second crash in the last window cycle
        ronda(5, 0);       // second crash one cycle too late
        ronda(1, 1);       // same-cycle crash
        ronda(-1, 0);      // player 1 reaches the winning score
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        ronda(-1, 0);

        espera(M_JOGO, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk("in_decide", 32'(m_fase), 32'(M_DECIDE));
        #2 reset = 1'b1;
        #1;
        chk("rst_reiniciar",  32'(bus.reiniciar),   32'd1);
        chk("rst_jogo_ativo", 32'(bus.jogo_ativo),  32'd0);
        chk("rst_pontos1",    32'(bus.pontos_jog1), 32'd0);
        chk("rst_pontos2",    32'(bus.pontos_jog2), 32'd0);
        chk("rst_vencedor",   32'(bus.vencedor),    32'd0);
        chk("rst_HEX0",       32'(bus.HEX0),        32'h40);
        chk("rst_HEX1",       32'(bus.HEX1),        32'h40);
        chk("rst_HEX2",       32'(bus.HEX2),        32'h7F);
        bus.fim_jog2 = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        espera(M_JOGO, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        r1 = 1'b0; r2 = 1'b0; ri = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) r1 = ~r1;
            if ($urandom_range(0, 9) == 0) r2 = ~r2;
            if ($urandom_range(0, 4) == 0) ri = ~ri;
            if ($urandom_range(0, 40) == 0) begin r1 = 1'b1; r2 = 1'b1; end
            if ($urandom_range(0, 40) == 0) begin r1 = 1'b0; r2 = 1'b0; end
            tick(r1, r2, ri);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
